ysyx_22040125_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV64 core. Each cycle it drives the load-enable and flush controls of the PC and of the IF/ID, ID/EXE and EXE/MEM pipeline registers. It resolves load-use hazards, taken-branch redirects and data-memory back-pressure, and it owns the multi-cycle mul/div FSM that holds an instruction in EXE until its result is ready.

---
 rtl/ysyx_22040125_pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040125_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_pipe_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EXE / EXE-MEM enables and flushes plus the mul/div hold FSM.
// Optional performance counters are enabled with `define YSYX_22040125_PERF_CNT_EN.
module ysyx_22040125_pipe_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       exe_valid,
  input  logic [4:0] exe_rd,
  input  logic       exe_wen,
  input  logic       exe_is_load,
  input  logic       exe_muldiv,
  input  logic       exe_is_div,
  input  logic       exe_branch_taken,
  input  logic       mem_busy,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_exe_en,
  output logic       exe_mem_en,
  output logic       if_id_flush,
  output logic       id_exe_flush,
  output logic       muldiv_busy,
  output logic       muldiv_done
`ifdef YSYX_22040125_PERF_CNT_EN
  ,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT) > 5) ? $clog2(MAX_LAT) : 5;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic md_start;
  logic mstall;
  logic luh;
  logic branch_fire;

  // A taken branch squashes the EXE instruction, so it must never launch the FSM.
  assign md_start = exe_valid & exe_muldiv & ~exe_branch_taken;
  assign mstall   = ((state_q == S_IDLE) & md_start) | (state_q == S_BUSY);

  assign luh = exe_valid & exe_is_load & exe_wen & (exe_rd != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == exe_rd)) | (id_use_rs2 & (id_rs2 == exe_rd)));

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_start) begin
          state_d = S_BUSY;
          cnt_d   = exe_is_div ? DIV_CNT : MUL_CNT;
        end
      end
      S_BUSY: begin
        // Counting ignores mem_busy; only the DONE hand-off waits for memory.
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (!mem_busy) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_exe_en    = 1'b0;
    exe_mem_en   = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    branch_fire  = 1'b0;
    if (rst || mem_busy) begin
      // Everything frozen: reset outputs, or memory cannot retire.
    end else if (mstall) begin
      // EXE holds; EXE/MEM loads the bubble that results from EXE valid being masked upstream.
      exe_mem_en = 1'b1;
    end else if (exe_branch_taken) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      branch_fire  = 1'b1;
    end else if (luh) begin
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      pc_en      = 1'b1;
      if_id_en   = 1'b1;
      id_exe_en  = 1'b1;
      exe_mem_en = 1'b1;
    end
  end

  assign muldiv_busy = ~rst & (state_q == S_BUSY);
  assign muldiv_done = ~rst & (state_q == S_DONE);

`ifdef YSYX_22040125_PERF_CNT_EN
  logic [63:0] stall_cnt_q;
  logic [63:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en)      stall_cnt_q <= stall_cnt_q + 64'd1;
      if (branch_fire) flush_cnt_q <= flush_cnt_q + 64'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_branch_fire;
  assign unused_branch_fire = branch_fire;
`endif

endmodule

// File: tb/tb_ysyx_22040125_pipe_ctrl.sv
// Self-checking bench for ysyx_22040125_pipe_ctrl: timeline model compared every cycle plus directed literal checks.
module tb_ysyx_22040125_pipe_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       exe_valid;
  logic [4:0] exe_rd;
  logic       exe_wen, exe_is_load, exe_muldiv, exe_is_div, exe_branch_taken;
  logic       mem_busy;
  logic       pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush;
  logic       muldiv_busy, muldiv_done;
`ifdef YSYX_22040125_PERF_CNT_EN
  logic [63:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22040125_pipe_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .exe_valid        (exe_valid),
    .exe_rd           (exe_rd),
    .exe_wen          (exe_wen),
    .exe_is_load      (exe_is_load),
    .exe_muldiv       (exe_muldiv),
    .exe_is_div       (exe_is_div),
    .exe_branch_taken (exe_branch_taken),
    .mem_busy         (mem_busy),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .id_exe_en        (id_exe_en),
    .exe_mem_en       (exe_mem_en),
    .if_id_flush      (if_id_flush),
    .id_exe_flush     (id_exe_flush),
    .muldiv_busy      (muldiv_busy),
    .muldiv_done      (muldiv_done)
`ifdef YSYX_22040125_PERF_CNT_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush}
  logic [5:0] ctl;
  assign ctl = {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an op started in cycle s with latency L is busy in cycles s+1..s+L and done from s+L+1 until it retires.
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_lat    = 0;
  int          m_cyc    = 0;
  bit          m_perf_ok = 1'b0;
  longint      m_stalls = 0;
  longint      m_flushes = 0;

  always @(negedge clk) begin : model_cmp
    bit         e_busy, e_done, e_start, e_mstall, e_luh, e_br;
    logic [5:0] e_ctl;
    e_busy   = m_active && (m_cyc > m_start) && (m_cyc <= m_start + m_lat);
    e_done   = m_active && (m_cyc > m_start + m_lat);
    e_start  = !m_active && exe_valid && exe_muldiv && !exe_branch_taken;
    e_mstall = e_start || e_busy;
    e_luh    = exe_valid && exe_is_load && exe_wen && (exe_rd != 0) && id_valid &&
               ((id_use_rs1 && id_rs1 == exe_rd) || (id_use_rs2 && id_rs2 == exe_rd));
    e_br     = 1'b0;
    if (rst || mem_busy)        e_ctl = 6'b000000;
    else if (e_mstall)          e_ctl = 6'b000100;
    else if (exe_branch_taken) begin
      e_ctl = 6'b111111;
      e_br  = 1'b1;
    end
    else if (e_luh)             e_ctl = 6'b001101;
    else                        e_ctl = 6'b111100;

    check("model_ctl", 64'(ctl), 64'(e_ctl));
    check("model_busy", 64'(muldiv_busy), 64'(!rst && e_busy));
    check("model_done", 64'(muldiv_done), 64'(!rst && e_done));
`ifdef YSYX_22040125_PERF_CNT_EN
    if (m_perf_ok) begin
      check("model_perf_stall", perf_stall_cnt, 64'(m_stalls));
      check("model_perf_flush", perf_flush_cnt, 64'(m_flushes));
    end
`endif
    if (rst) begin
      m_active  = 1'b0;
      m_stalls  = 0;
      m_flushes = 0;
      m_perf_ok = 1'b1;
    end else begin
      if (e_ctl[5] == 1'b0) m_stalls++;
      if (e_br) m_flushes++;
      if (e_start) begin
        m_active = 1'b1;
        m_start  = m_cyc;
        m_lat    = exe_is_div ? DIV_LAT : MUL_LAT;
      end else if (e_done && !mem_busy) begin
        m_active = 1'b0;
      end
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    exe_valid = 1'b0; exe_rd = 5'd0; exe_wen = 1'b0; exe_is_load = 1'b0;
    exe_muldiv = 1'b0; exe_is_div = 1'b0; exe_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Load x5 in EXE, ID reads rs1=x3 and rs2=x5.
  task automatic set_luh(input logic [4:0] rd);
    clr();
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_wen = 1'b1; exe_rd = rd;
    id_use_rs1 = 1'b1; id_rs1 = 5'd3; id_use_rs2 = 1'b1; id_rs2 = rd;
  endtask

  task automatic set_md(input logic is_div);
    clr();
    exe_valid = 1'b1; exe_muldiv = 1'b1; exe_is_div = is_div; exe_wen = 1'b1; exe_rd = 5'd7;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    clr();
    settle();
    check("rst_ctl", 64'(ctl), 64'h0);
    check("rst_done", 64'(muldiv_done), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("idle_ctl", 64'(ctl), 64'b111100);

    // Load-use: one bubble, then normal; x0 destination never stalls.
    tick(); set_luh(5'd5); settle();
    check("luh_ctl", 64'(ctl), 64'b001101);
    tick(); clr(); settle();
    check("luh_after", 64'(ctl), 64'b111100);
    tick(); set_luh(5'd0); settle();
    check("luh_x0", 64'(ctl), 64'b111100);

    // Back-to-back multiplies: starts in cycles 1 and 6, done in 5 and 10.
    tick(); set_md(1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      settle();
      check("mul_pc_en", 64'(pc_en), 64'((c == 5) || (c == 10)));
      check("mul_busy", 64'(muldiv_busy), 64'((c >= 2 && c <= 4) || (c >= 7 && c <= 9)));
      check("mul_done", 64'(muldiv_done), 64'((c == 5) || (c == 10)));
    end
    tick(); clr(); settle();
    check("mul_idle_done", 64'(muldiv_done), 64'h0);

    // Divide: mem_busy in one BUSY cycle (count continues) and the first two DONE cycles.
    tick(); set_md(1'b1);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      mem_busy = (c == 6) || (c == 18) || (c == 19);
      settle();
      check("div_busy", 64'(muldiv_busy), 64'(c >= 2 && c <= 17));
      check("div_done", 64'(muldiv_done), 64'(c >= 18));
      if (mem_busy) check("div_membusy_ctl", 64'(ctl), 64'h0);
    end
    check("div_release_ctl", 64'(ctl), 64'b111100);
    tick(); clr(); settle();
    check("div_idle_done", 64'(muldiv_done), 64'h0);

    // Branch beats load-use; branch beats mul/div start.
    tick(); set_luh(5'd5); exe_branch_taken = 1'b1; settle();
    check("br_luh_ctl", 64'(ctl), 64'b111111);
    tick(); set_md(1'b0); exe_branch_taken = 1'b1; settle();
    check("br_md_ctl", 64'(ctl), 64'b111111);
    tick(); clr(); settle();
    check("br_md_busy", 64'(muldiv_busy), 64'h0);

    // Reset on the second BUSY cycle of a divide aborts it.
    tick(); set_md(1'b1);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      if (c == 3) rst = 1'b1;
      settle();
      if (c == 2) check("abort_busy1", 64'(muldiv_busy), 64'h1);
    end
    check("abort_rst_ctl", 64'(ctl), 64'h0);
    check("abort_rst_busy", 64'(muldiv_busy), 64'h0);
    tick(); rst = 1'b0; clr();
    for (int c = 0; c < 20; c++) begin
      settle();
      check("abort_no_done", 64'(muldiv_done), 64'h0);
      check("abort_no_busy", 64'(muldiv_busy), 64'h0);
      tick();
    end

`ifdef YSYX_22040125_PERF_CNT_EN
    rst = 1'b1; clr(); settle();
    tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_luh(5'd5); settle(); tick();
      clr(); settle(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      clr(); exe_valid = 1'b1; exe_branch_taken = 1'b1; settle(); tick();
      clr(); settle(); tick();
    end
    settle();
    check("perf_stall", perf_stall_cnt, 64'd3);
    check("perf_flush", perf_flush_cnt, 64'd2);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
